// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder
//
// Memory-side responder for the LC-3b datapath. Accepts one word read or
// write at a time from the control unit, waits WAIT_STATES cycles, then
// completes with a one-cycle ready pulse on R. Read data is driven onto
// the shared Data bus only during that ready cycle. It stands in for
// off-chip SRAM in simulation and on the FPGA build.
//
// Parameters
//   DEPTH_LOG2   log2 of the number of 16-bit words held (default 8)
//   WAIT_STATES  cycles between request acceptance and response, 0..15
//
// Ports
//   Clk     system clock, rising edge
//   Reset   asynchronous active-low reset
//   ADDR    word address; only ADDR[DEPTH_LOG2-1:0] is decoded
//   Data    shared bus: sampled on write accept, driven for read response
//   MEM_EN  request strobe, held by control until R is seen
//   MEM_WE  1 = write, 0 = read, qualified by MEM_EN
//   R       ready, high for exactly one cycle per completed transaction
//   Busy    high in every state except idle

module lc3b_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  input  logic        MEM_EN,
  input  logic        MEM_WE,
  output logic        R,
  output logic        Busy
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [3:0]            count;
  logic [DEPTH_LOG2-1:0] req_addr;
  logic                  req_we;
  logic [15:0]           req_data;
  logic [15:0]           rd_data;
  logic                  drive;

  // Not reset: contents are undefined after power-up, like the SRAM it models.
  logic [15:0] mem [DEPTH];

  // Address bits above the decoded range alias onto the same words.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ADDR[19:DEPTH_LOG2];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (MEM_EN) begin
          state_nxt = (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // MEM_EN is deliberately ignored here: a dropped strobe does not abort.
        if (count <= 4'd1) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_HOLD;
      ST_HOLD: begin
        // Wait for the strobe to fall so a still-high MEM_EN cannot
        // launch a duplicate transaction.
        if (!MEM_EN) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      req_addr <= '0;
      req_we   <= 1'b0;
      req_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (MEM_EN) begin
            req_addr <= ADDR[DEPTH_LOG2-1:0];
            req_we   <= MEM_WE;
            req_data <= Data;
            count    <= WAIT_INIT;
          end
        end
        ST_WAIT: count <= count - 4'd1;
        default: ;
      endcase
    end
  end

  // The write commits on the edge leaving RESP. Gating with Reset keeps an
  // interrupted write from touching the array.
  always_ff @(posedge Clk) begin
    if (Reset && (state == ST_RESP) && req_we) begin
      mem[req_addr] <= req_data;
    end
  end

  assign rd_data = mem[req_addr];
  assign drive   = (state == ST_RESP) && !req_we;
  assign Data    = drive ? rd_data : 'z;
  assign R       = (state == ST_RESP);
  assign Busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb_lc3b_mem_responder
//
// Drives two responders (default WAIT_STATES=2, and WAIT_STATES=0) with
// directed transactions. Expected responses go into a queue when a request
// is issued; a monitor pops and compares whenever a DUT raises R.

module tb_lc3b_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  en;
  logic [1:0]  we;
  logic [1:0]  drv;
  logic [19:0] addr  [2];
  logic [15:0] wdata [2];
  logic [1:0]  r;
  logic [1:0]  busy;
  tri1  [15:0] bus0;
  tri1  [15:0] bus1;

  int unsigned cyc         = 0;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic        mon_on      = 1'b0;

  typedef struct {
    int unsigned d;
    logic        we;
    logic [15:0] data;
    int unsigned at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  lc3b_mem_responder u_dut (
    .Clk    (clk),
    .Reset  (rst_n),
    .ADDR   (addr[0]),
    .Data   (bus0),
    .MEM_EN (en[0]),
    .MEM_WE (we[0]),
    .R      (r[0]),
    .Busy   (busy[0])
  );

  lc3b_mem_responder #(.WAIT_STATES(0)) u_dut_ws0 (
    .Clk    (clk),
    .Reset  (rst_n),
    .ADDR   (addr[1]),
    .Data   (bus1),
    .MEM_EN (en[1]),
    .MEM_WE (we[1]),
    .R      (r[1]),
    .Busy   (busy[1])
  );

  assign bus0 = drv[0] ? wdata[0] : 'z;
  assign bus1 = drv[1] ? wdata[1] : 'z;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned ws(input int unsigned d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [15:0] bus(input int unsigned d);
    return (d == 0) ? bus0 : bus1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every R pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        if (r[d] === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected R", 32'(r[d]), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("R from dut", 32'(d), 32'(mon_e.d));
            check("R cycle", 32'(cyc), 32'(mon_e.at));
            if (!mon_e.we) check("read data", 32'(bus(d)), 32'(mon_e.data));
            else           check("write resp bus Z", 32'(bus(d)), 32'h0000_FFFF);
          end
        end else if (!drv[d]) begin
          check("bus Z", 32'(bus(d)), 32'h0000_FFFF);
        end
      end
    end
  end

  // One transaction on dut d; hold = extra cycles MEM_EN stays high after R.
  task automatic txn(input int unsigned d, input logic w, input logic [19:0] a,
                     input logic [15:0] wd, input logic [15:0] rd_exp,
                     input int unsigned hold);
    exp_t        e;
    int unsigned waited;
    @(negedge clk);
    check("idle Busy", 32'(busy[d]), 32'd0);
    en[d]    = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    drv[d]   = w;
    e.d    = d;
    e.we   = w;
    e.data = rd_exp;
    e.at   = cyc + 1 + ws(d);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("Busy after accept", 32'(busy[d]), 32'd1);
    // Scramble inputs: only the latched request may be used.
    drv[d]   = 1'b0;
    addr[d]  = a ^ 20'h000FF;
    we[d]    = ~w;
    wdata[d] = ~wd;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (r[d] !== 1'b1 && waited < 40);
    if (r[d] !== 1'b1) check("R timeout", 32'(r[d]), 32'd1);
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      check("Busy in HOLD", 32'(busy[d]), 32'd1);
    end
    en[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    en = '0; we = '0; drv = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    #12;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset R", 32'(r[d]), 32'd0);
      check("reset Busy", 32'(busy[d]), 32'd0);
      check("reset bus Z", 32'(bus(d)), 32'h0000_FFFF);
    end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // WAIT_STATES=2: round trip, aliasing, held strobe
    txn(0, 1'b1, 20'h00010, 16'h1234, 16'h0000, 0);
    txn(0, 1'b0, 20'h00010, 16'h0000, 16'h1234, 0);
    txn(0, 1'b1, 20'h00105, 16'hBEEF, 16'h0000, 0);
    txn(0, 1'b0, 20'h00005, 16'h0000, 16'hBEEF, 0);
    txn(0, 1'b0, 20'h00010, 16'h0000, 16'h1234, 6);
    txn(0, 1'b0, 20'h00005, 16'h0000, 16'hBEEF, 0);
    txn(0, 1'b1, 20'h00020, 16'h5555, 16'h0000, 0);

    // Reset during WAIT of a write: no R, array untouched
    @(negedge clk);
    en[0] = 1'b1; we[0] = 1'b1; addr[0] = 20'h00020; wdata[0] = 16'hAAAA; drv[0] = 1'b1;
    @(posedge clk);
    #1;
    drv[0] = 1'b0;
    en[0]  = 1'b0;
    check("Busy in WAIT", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset R", 32'(r[0]), 32'd0);
    check("mid reset Busy", 32'(busy[0]), 32'd0);
    check("mid reset bus Z", 32'(bus0), 32'h0000_FFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 20'h00020, 16'h0000, 16'h5555, 0);
    txn(0, 1'b0, 20'hABC20, 16'h0000, 16'h5555, 0);

    // WAIT_STATES=0: response in the cycle after accept, back-to-back
    txn(1, 1'b1, 20'h00003, 16'hC0DE, 16'h0000, 0);
    txn(1, 1'b1, 20'h00104, 16'h0F0F, 16'h0000, 0);
    txn(1, 1'b0, 20'h00003, 16'h0000, 16'hC0DE, 0);
    txn(1, 1'b0, 20'h00004, 16'h0000, 16'h0F0F, 0);
    txn(1, 1'b0, 20'hFFF03, 16'h0000, 16'hC0DE, 0);

    repeat (4) @(negedge clk);
    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
